// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC datapath definitions used by the register file block.
package kgp_risc_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] RA_IDX   = 5'd31;
    localparam logic [ADDR_W-1:0] ZERO_IDX = 5'd0;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } regfile_state_t;
endpackage

// File: rtl/regfile_bank_if.sv
// Write-back / operand-read bus of the register file.
// master: decode/ALU + write-back side; slave: the register file.
interface regfile_bank_if;
    import kgp_risc_pkg::*;

    logic [ADDR_W-1:0] rsAddr;
    logic [ADDR_W-1:0] rtAddr;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] raData;
    logic [ADDR_W-1:0] wrAddr;
    logic              RegWrite;
    logic [DATA_W-1:0] wrData;
    logic              ready;
    logic              wr_dropped;

    modport master (
        output rsAddr, rtAddr, wrAddr, RegWrite, wrData,
        input  rsData, rtData, raData, ready, wr_dropped
    );

    modport slave (
        input  rsAddr, rtAddr, wrAddr, RegWrite, wrData,
        output rsData, rtData, raData, ready, wr_dropped
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx over every register writing zero,
// then reports ready. Also flags write-back writes lost while clearing.
module regfile_clear_seq
    import kgp_risc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              ready,
    output logic              wr_dropped
);
    regfile_state_t    state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic              wr_dropped_q, wr_dropped_d;

    // Next-state: advance the clear index, leave CLEAR after the last register.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        ready_d      = ready_q;
        wr_dropped_d = 1'b0;
        if (state_q == CLEAR) begin
            clr_idx_d    = clr_idx_q + 1'b1;
            // Writes to r0 are architecturally ignored, so they are not "dropped".
            wr_dropped_d = reg_write && (wr_addr != ZERO_IDX);
            if (clr_idx_q == {ADDR_W{1'b1}}) begin
                state_d   = READY;
                ready_d   = 1'b1;
                clr_idx_d = '0;
            end
        end
    end

    // State registers; reset restarts the clear from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            ready_q      <= 1'b0;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            ready_q      <= ready_d;
            wr_dropped_q <= wr_dropped_d;
        end
    end

    // Array must not be touched on an edge where rst is high.
    assign clr_we     = (state_q == CLEAR) && !rst;
    assign clr_idx    = clr_idx_q;
    assign ready      = ready_q;
    assign wr_dropped = wr_dropped_q;
endmodule

// File: rtl/regfile_bank.sv
// 32 x 32-bit register file: storage, clear/write-back write mux, read muxes.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic           clk,
    input  logic           rst,
    regfile_bank_if.slave  bus
);
    import kgp_risc_pkg::*;

    logic [DATA_W-1:0] mem_q [NREGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_val;
    logic              wb_hit;

    regfile_clear_seq u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (bus.RegWrite),
        .wr_addr    (bus.wrAddr),
        .clr_we     (clr_we),
        .clr_idx    (clr_idx),
        .ready      (ready),
        .wr_dropped (bus.wr_dropped)
    );

    // Write-back write that actually lands in READY (r0 never stored).
    assign wb_hit = ready && bus.RegWrite && (bus.wrAddr != ZERO_IDX[ADDR_W-1:0]);

    // Write port select: the clear sequencer owns the array until ready.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = clr_idx;
        wr_val = '0;
        if (clr_we) begin
            wr_en = 1'b1;
        end else if (wb_hit && !rst) begin
            wr_en  = 1'b1;
            wr_idx = bus.wrAddr;
            wr_val = bus.wrData;
        end
    end

    // Storage array; no reset, contents survive rst until re-cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_val;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit && (bus.wrAddr == addr)) begin
            val = bus.wrData;
        end
`endif
        if (!ready || (addr == ZERO_IDX[ADDR_W-1:0])) begin
            val = '0;
        end
        return val;
    endfunction

    // Combinational operand reads, zero while the array is being cleared.
    always_comb begin
        bus.rsData = rd_port(bus.rsAddr);
        bus.rtData = rd_port(bus.rtAddr);
        bus.raData = rd_port(RA_IDX[ADDR_W-1:0]);
    end

    assign bus.ready = ready;
endmodule

// File: doc/regfile_bank.md
# regfile_bank

32 × 32-bit general-purpose register file for the KGP-RISC datapath: the read side and storage end of the write-back path. It takes the write-back triple (wrAddr, RegWrite, wrData) and serves the rs, rt and return-address operands to decode/ALU. After reset, a clear sequencer zeroes the array one entry per cycle. A ready flag holds the pipeline off until clearing completes.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- NREGS, 32, number of registers, equal to 2**ADDR_W

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- rsAddr  in  ADDR_W  read port A index
- rtAddr  in  ADDR_W  read port B index
- rsData  out  DATA_W  contents of rsAddr, combinational
- rtData  out  DATA_W  contents of rtAddr, combinational
- raData  out  DATA_W  contents of register 31 ($ra), combinational
- wrAddr  in  ADDR_W  write index from write-back
- RegWrite  in  1  write enable from write-back
- wrData  in  DATA_W  write data from write-back
- ready  out  1  clear complete; array valid
- wr_dropped  out  1  one-cycle pulse when a RegWrite is discarded during CLEAR

## Operation
- FSM states:
  - CLEAR (reset state): clr_idx counts 0..31. Each cycle with rst low writes 0 to mem[clr_idx], then increments clr_idx. On the edge that clears index 31, go to READY.
  - READY: normal operation. Leaves only on rst.
- Writes in READY: on the edge with RegWrite=1 and wrAddr≠0, mem[wrAddr] ← wrData.
- Register 0:
  - Writes to index 0 are silently ignored; wr_dropped is not raised.
  - Reads of index 0 always return 0.
- Writes in CLEAR: discarded. If RegWrite=1, wrAddr≠0 and rst=0, wr_dropped=1 for the following cycle.
- Reads in CLEAR: rsData, rtData and raData are forced to 0 regardless of array contents.
- Reads in READY: rsData = mem[rsAddr], rtData = mem[rtAddr], raData = mem[31], subject to the bypass rule under Configuration.
- No arithmetic beyond the clr_idx increment. clr_idx is ADDR_W bits and is never used past 31.

## Timing
- Reset values, on any edge with rst=1: state=CLEAR, clr_idx=0, ready=0, wr_dropped=0. Array contents are untouched on that edge.
- rst held high for several cycles: state stays CLEAR with clr_idx held at 0.
- Clear latency: ready rises exactly 32 edges after the first edge with rst=0.
- Reset mid-clear: restarts from clr_idx=0; full 32 cycles again.
- Reset in READY: same as mid-clear. A RegWrite on the same edge as rst=1 is discarded and wr_dropped stays 0.
- Write latency: one edge; data is visible on read ports in the cycle after the write edge.
- Simultaneous read and write of the same index in READY: governed by REGFILE_BYPASS_EN.
- wr_dropped is registered and lasts one cycle per dropped write.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, if RegWrite=1, wrAddr≠0 and a read address equals wrAddr, that port returns wrData in the same cycle. raData forwards when wrAddr=31.
- Undefined: read ports always return the stored array value, i.e. the old value during a same-cycle write.

## Structure
- Shared package kgp_risc_pkg holds:
  - DATA_W, ADDR_W
  - RA_IDX = 5'd31, ZERO_IDX = 5'd0
  - the two-state enum regfile_state_t {CLEAR, READY}
- Sub-module regfile_clear_seq: owns the FSM, clr_idx, ready and wr_dropped. It outputs clr_we and clr_idx to the storage block.
- Array storage, write mux (clear vs. write-back) and read/bypass muxing stay in regfile_bank.

## Test plan
- Reset then clear: rst high 3 cycles then low → ready=0 for 32 cycles, 1 on cycle 32. rsAddr=5 reads 0 throughout, including after pre-loading garbage via the reset-free power-up state.
- Basic write/read: READY; write 0xDEADBEEF to r7 → next cycle rsAddr=7 and rtAddr=7 both read 0xDEADBEEF.
- Register 0 and ra:
  - write 0x12345678 to r0 → r0 reads 0 and wr_dropped stays 0.
  - write 0x00400010 to r31 → raData=0x00400010 next cycle.
- Same-cycle hazard: write 0xA5A5A5A5 to r3 while rsAddr=3, with r3 previously 0x11 → rsData=0xA5A5A5A5 in that cycle with REGFILE_BYPASS_EN defined, 0x11 without.
- Dropped write and reset mid-clear:
  - RegWrite to r9 at clear cycle 10 → wr_dropped pulses one cycle, and r9=0 after ready.
  - rst asserted at clear cycle 20 → ready rises 32 cycles after its release.
